// File: rtl/hb_pkg.sv
// Shared types and constants for the hb_bcd_conv binary-to-BCD converter.
package hb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } hb_state_e;

    localparam logic [3:0] BCD_BLANK = 4'hF;

endpackage

// File: rtl/hb_bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
module hb_bcd_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Pre-shift correction so the digit stays in 0..9 after doubling.
    always_comb begin
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end else begin
            digit_o = digit_i;
        end
    end

endmodule

// File: rtl/hb_bcd_conv.sv
// Sequential binary-to-BCD converter (one double-dabble step per clock).
// Optional leading-zero blanking is enabled by defining HB_BCD_LEADING_BLANK_EN.
module hb_bcd_conv
    import hb_pkg::*;
#(
    parameter int IN_W   = 6,
    parameter int DIGITS = 2
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  START,
    input  logic                  MOD,
    input  logic [IN_W-1:0]       NUMBER,
    input  logic [IN_W-1:0]       ANUMBER,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   DIGIT_OUT,
    output logic                  OVF
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IN_W + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(IN_W - 1);

    hb_state_e         state_q;
    logic [IN_W-1:0]   opnd_q;
    logic [BW-1:0]     bcd_q;
    logic              sticky_q;
    logic [CW-1:0]     cnt_q;
    logic [BW-1:0]     dout_q;
    logic              ovf_q;
    logic              done_q;
    logic              busy_q;

    logic [BW-1:0]     adj_s;
    logic [BW-1:0]     bcd_d;
    logic              carry_s;
    logic              fin_ovf_s;
    logic [BW-1:0]     result_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        hb_bcd_add3 u_add3 (
            .digit_i (bcd_q[4*g +: 4]),
            .digit_o (adj_s[4*g +: 4])
        );
    end

    // The bit leaving the top digit on the shift is the overflow indicator.
    assign bcd_d     = {adj_s[BW-2:0], opnd_q[IN_W-1]};
    assign carry_s   = adj_s[BW-1];
    assign fin_ovf_s = sticky_q | carry_s;

`ifdef HB_BCD_LEADING_BLANK_EN
    logic lead_s;
`endif

    // Final presentation value: zero on overflow, optionally with leading zeros blanked.
    always_comb begin
        if (fin_ovf_s) begin
            result_d = '0;
        end else begin
            result_d = bcd_d;
        end
`ifdef HB_BCD_LEADING_BLANK_EN
        lead_s = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead_s && (result_d[4*i +: 4] == 4'd0)) begin
                result_d[4*i +: 4] = BCD_BLANK;
            end else begin
                lead_s = 1'b0;
            end
        end
`endif
    end

    // Control FSM with conversion datapath and registered outputs.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= IDLE;
            opnd_q   <= '0;
            bcd_q    <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (START) begin
                        opnd_q   <= MOD ? ANUMBER : NUMBER;
                        bcd_q    <= '0;
                        sticky_q <= 1'b0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= SHIFT;
                    end else begin
                        busy_q   <= 1'b0;
                    end
                end
                SHIFT: begin
                    bcd_q    <= bcd_d;
                    opnd_q   <= opnd_q << 1;
                    sticky_q <= fin_ovf_s;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST_STEP) begin
                        dout_q  <= result_d;
                        ovf_q   <= fin_ovf_s;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        state_q <= SHIFT;
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign DIGIT_OUT = dout_q;
    assign OVF       = ovf_q;

endmodule

// File: tb/tb_hb_bcd_conv.sv
// Scoreboard bench for hb_bcd_conv: default instance plus IN_W=8 instances with 2 and 3 digits.
module tb_hb_bcd_conv;

`ifdef HB_BCD_LEADING_BLANK_EN
    localparam bit BL = 1'b1;
`else
    localparam bit BL = 1'b0;
`endif

    typedef struct {
        logic [11:0] d;
        logic        o;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       a_start = 1'b0, a_mod = 1'b0;
    logic [5:0] a_num = '0, a_anum = '0;
    logic       a_busy, a_done, a_ovf;
    logic [7:0] a_dout;

    logic       b_start = 1'b0;
    logic [7:0] b_num = '0;
    logic [7:0] b_anum = '0;
    logic       b8_busy, b8_done, b8_ovf, b3_busy, b3_done, b3_ovf;
    logic [7:0] b8_dout;
    logic [11:0] b3_dout;

    int total = 0;
    int bad = 0;
    int a_done_cnt = 0;
    exp_t qa[$], q8[$], q3[$];

    always #5 clk = ~clk;

    hb_bcd_conv u_dut (
        .CLK(clk), .RESETN(rst_n), .START(a_start), .MOD(a_mod),
        .NUMBER(a_num), .ANUMBER(a_anum), .BUSY(a_busy), .DONE(a_done),
        .DIGIT_OUT(a_dout), .OVF(a_ovf)
    );

    hb_bcd_conv #(.IN_W(8), .DIGITS(2)) u_dut8 (
        .CLK(clk), .RESETN(rst_n), .START(b_start), .MOD(1'b0),
        .NUMBER(b_num), .ANUMBER(b_anum), .BUSY(b8_busy), .DONE(b8_done),
        .DIGIT_OUT(b8_dout), .OVF(b8_ovf)
    );

    hb_bcd_conv #(.IN_W(8), .DIGITS(3)) u_dut3 (
        .CLK(clk), .RESETN(rst_n), .START(b_start), .MOD(1'b0),
        .NUMBER(b_num), .ANUMBER(b_anum), .BUSY(b3_busy), .DONE(b3_done),
        .DIGIT_OUT(b3_dout), .OVF(b3_ovf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pop the expected result whenever any instance pulses DONE.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            if (a_done) begin
                a_done_cnt++;
                if (qa.size() == 0) chk("a_unexpected_done", 32'd1, 32'd0);
                else begin
                    e = qa.pop_front();
                    chk("a_digits", {24'd0, a_dout}, {24'd0, e.d[7:0]});
                    chk("a_ovf", {31'd0, a_ovf}, {31'd0, e.o});
                end
            end
            if (b8_done) begin
                if (q8.size() == 0) chk("b8_unexpected_done", 32'd1, 32'd0);
                else begin
                    e = q8.pop_front();
                    chk("b8_digits", {24'd0, b8_dout}, {24'd0, e.d[7:0]});
                    chk("b8_ovf", {31'd0, b8_ovf}, {31'd0, e.o});
                end
            end
            if (b3_done) begin
                if (q3.size() == 0) chk("b3_unexpected_done", 32'd1, 32'd0);
                else begin
                    e = q3.pop_front();
                    chk("b3_digits", {20'd0, b3_dout}, {20'd0, e.d});
                    chk("b3_ovf", {31'd0, b3_ovf}, {31'd0, e.o});
                end
            end
        end
    end

    task automatic run_a(input logic mod, input logic [5:0] num, input logic [5:0] anum,
                         input logic [7:0] ed, input logic eo);
        int cyc;
        int busy_n;
        qa.push_back('{d: {4'd0, ed}, o: eo});
        @(negedge clk);
        a_mod = mod; a_num = num; a_anum = anum; a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        cyc = 1;
        busy_n = 0;
        while (!a_done && cyc < 30) begin
            busy_n += a_busy;
            if (cyc == 2) begin
                a_mod = ~mod; a_num = ~num; a_anum = ~anum;
            end
            @(posedge clk); #1;
            cyc++;
        end
        busy_n += a_busy;
        chk("a_latency", cyc, 32'd7);
        chk("a_busy_cycles", busy_n, 32'd7);
        repeat (2) @(posedge clk);
        #1;
        chk("a_hold_digits", {24'd0, a_dout}, {24'd0, ed});
        chk("a_idle_busy", {31'd0, a_busy}, 32'd0);
    endtask

    task automatic run_b(input logic [7:0] num, input logic [7:0] e8d, input logic e8o,
                         input logic [11:0] e3d, input logic e3o);
        int cyc;
        q8.push_back('{d: {4'd0, e8d}, o: e8o});
        q3.push_back('{d: e3d, o: e3o});
        @(negedge clk);
        b_num = num; b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        cyc = 1;
        while (!b8_done && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("b8_latency", cyc, 32'd9);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int n0;
        #12;
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_done", {31'd0, a_done}, 32'd0);
        chk("rst_digits", {24'd0, a_dout}, 32'd0);
        chk("rst_ovf", {31'd0, a_ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_a(1'b0, 6'd47, 6'd0,  8'h47, 1'b0);
        run_a(1'b1, 6'd12, 6'd59, 8'h59, 1'b0);
        run_a(1'b1, 6'd12, 6'd0,  BL ? 8'hF0 : 8'h00, 1'b0);
        run_a(1'b1, 6'd12, 6'd63, 8'h63, 1'b0);

        // Second START mid-conversion plus input change must be ignored.
        n0 = a_done_cnt;
        qa.push_back('{d: 12'h047, o: 1'b0});
        @(negedge clk);
        a_mod = 1'b0; a_num = 6'd47; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        @(negedge clk);
        a_num = 6'd10; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (25) @(negedge clk);
        chk("a_single_done", a_done_cnt - n0, 32'd1);

        // Reset in the middle of SHIFT aborts without a DONE pulse.
        n0 = a_done_cnt;
        @(negedge clk);
        a_num = 6'd33; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, a_busy}, 32'd0);
        chk("abort_done", {31'd0, a_done}, 32'd0);
        chk("abort_digits", {24'd0, a_dout}, 32'd0);
        chk("abort_ovf", {31'd0, a_ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_no_done", a_done_cnt - n0, 32'd0);
        chk("abort_digits_held", {24'd0, a_dout}, 32'd0);
        run_a(1'b0, 6'd5, 6'd0, BL ? 8'hF5 : 8'h05, 1'b0);

        // START held high: back-to-back conversions every IN_W+2 cycles.
        qa.push_back('{d: 12'h021, o: 1'b0});
        qa.push_back('{d: 12'h021, o: 1'b0});
        @(negedge clk);
        a_mod = 1'b0; a_num = 6'd21; a_start = 1'b1;
        cyc = 0;
        while (!a_done && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!a_done && cyc < 30);
        a_start = 1'b0;
        chk("a_b2b_period", cyc, 32'd8);
        repeat (12) @(negedge clk);

        run_b(8'd123, BL ? 8'hF0 : 8'h00, 1'b1, 12'h123, 1'b0);
        run_b(8'd99,  8'h99, 1'b0, BL ? 12'hF99 : 12'h099, 1'b0);
        run_b(8'd7,   BL ? 8'hF7 : 8'h07, 1'b0, BL ? 12'hFF7 : 12'h007, 1'b0);
        run_b(8'd0,   BL ? 8'hF0 : 8'h00, 1'b0, BL ? 12'hFF0 : 12'h000, 1'b0);
        run_b(8'd105, BL ? 8'hF0 : 8'h00, 1'b1, 12'h105, 1'b0);
        run_b(8'd255, BL ? 8'hF0 : 8'h00, 1'b1, 12'h255, 1'b0);

        repeat (4) @(negedge clk);
        chk("qa_drained", qa.size(), 32'd0);
        chk("q8_drained", q8.size(), 32'd0);
        chk("q3_drained", q3.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hb_bcd_conv.md
HB_BCD_CONV -- requirements
Module: hb_bcd_conv

Interface
REQ-001 Parameter IN_W, default 6: width of the binary input operands.
REQ-002 Parameter DIGITS, default 2: number of BCD digits produced, at least 1.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RESETN  input  1  asynchronous, active-low reset.
REQ-005 START  input  1  conversion request; sampled only in IDLE.
REQ-006 MOD  input  1  source select, sampled with START: 0 selects NUMBER, 1 selects ANUMBER.
REQ-007 NUMBER  input  IN_W  time value, unsigned binary.
REQ-008 ANUMBER  input  IN_W  alarm value, unsigned binary.
REQ-009 BUSY  output  1  high while a conversion is in progress (SHIFT or FIN state).
REQ-010 DONE  output  1  one-cycle pulse when new results become valid.
REQ-011 DIGIT_OUT  output  4*DIGITS  BCD result; digit 0 (units) in bits [3:0], tens in bits [7:4], and so on.
REQ-012 OVF  output  1  high when the last converted value exceeded 10^DIGITS-1.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and FIN.
REQ-014 In IDLE with START=1, the block SHALL capture the MOD-selected operand, clear the BCD accumulator and sticky overflow, and enter SHIFT.
REQ-015 SHIFT SHALL run exactly IN_W cycles, performing one double-dabble step per cycle: add 3 to each digit that is >=5, then shift left 1 bit, taking in the operand MSB.
REQ-016 A 1 shifted out of the top digit during SHIFT SHALL set sticky overflow.
REQ-017 After the last SHIFT cycle the FSM SHALL enter FIN for one cycle and then return to IDLE.
REQ-018 On entry to FIN, DIGIT_OUT and OVF SHALL update together, and DONE SHALL be high for exactly that cycle; the START-to-DONE latency is IN_W+1 cycles.
REQ-019 When overflow is set, DIGIT_OUT SHALL be all zeros and OVF SHALL be 1.
REQ-020 DIGIT_OUT and OVF SHALL hold their values between completions.
REQ-021 START while BUSY=1 SHALL be ignored and not queued; changes to NUMBER, ANUMBER or MOD after capture SHALL not affect the result in progress.
REQ-022 START held high SHALL start a new conversion in the cycle immediately after FIN, giving back-to-back conversions every IN_W+2 cycles.

Reset
REQ-023 RESETN low SHALL immediately force state IDLE, BUSY=0, DONE=0, DIGIT_OUT=0, OVF=0, and clear all internal registers.
REQ-024 Reset during SHIFT or FIN SHALL abort the conversion, with no DONE pulse and no output update.
REQ-025 The first START is honoured on the first rising edge after RESETN deasserts.

Configuration
REQ-026 Macro HB_BCD_LEADING_BLANK_EN defined: at FIN, each leading zero digit above digit 0 SHALL be replaced by 4'hF (blank code); digit 0 is never blanked, and an overflow result also blanks all upper digits.
REQ-027 Macro HB_BCD_LEADING_BLANK_EN undefined: DIGIT_OUT SHALL present plain BCD, leading zeros included.

Structure
REQ-028 Shared package hb_pkg SHALL hold the FSM state typedef (IDLE/SHIFT/FIN) and the constant BCD_BLANK = 4'hF.
REQ-029 Sub-module hb_bcd_add3 SHALL implement the per-digit conditional add-3 cell, instantiated DIGITS times via generate.

Verification
REQ-030 Defaults, MOD=0, NUMBER=47, START pulse: DONE exactly 7 cycles later, DIGIT_OUT=8'h47, OVF=0, BUSY high for 7 cycles.
REQ-031 Defaults, MOD=1, NUMBER=12, ANUMBER=59: DIGIT_OUT=8'h59; repeat with ANUMBER=0 gives 8'h00; ANUMBER=63 gives 8'h63.
REQ-032 IN_W=8, DIGITS=2, input 123: DIGIT_OUT=8'h00, OVF=1; then input 99: DIGIT_OUT=8'h99, OVF=0.
REQ-033 Second START mid-conversion and NUMBER changed at cycle 2: single DONE pulse carrying the first-captured value.
REQ-034 RESETN pulsed low at SHIFT cycle 3: no DONE pulse, outputs zero; a following START with value 5 gives 8'h05.
REQ-035 With HB_BCD_LEADING_BLANK_EN defined, DIGITS=3, IN_W=8, input 7: DIGIT_OUT=12'hFF7; input 0: 12'hFF0; input 105: 12'h105.
